// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and the transfer alignment rule
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_BYTE    = 3'd0;
  localparam logic [2:0] HSIZE_HALF    = 3'd1;
  localparam logic [2:0] HSIZE_WORD    = 3'd2;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;
  function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] addr);
    return size == HSIZE_BYTE || (size == HSIZE_HALF && !addr[0]) || (size == HSIZE_WORD && addr == 2'b00);
  endfunction
endpackage

// File: rtl/ahb_lane_mux.sv
// ahb_lane_mux: write-lane replication and read-lane extraction by size and address
module ahb_lane_mux
  import ahb_pkg::*;
(
  input  logic [2:0]  wr_size,
  input  logic [31:0] wr_data,
  output logic [31:0] wr_lanes,
  input  logic [2:0]  rd_size,
  input  logic [1:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [31:0] rd_lane
);
  // replicate right-justified write data across all lanes; pick the addressed read lane
  always_comb begin
    wr_lanes = wr_size == HSIZE_BYTE ? {4{wr_data[7:0]}} :
               wr_size == HSIZE_HALF ? {2{wr_data[15:0]}} : wr_data;
    rd_lane  = rd_size == HSIZE_BYTE ? 32'(rd_data[{rd_addr, 3'b000} +: 8]) :
               rd_size == HSIZE_HALF ? 32'(rd_data[{rd_addr[1], 4'b0000} +: 16]) : rd_data;
  end
endmodule

// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: valid/ready command port to AHB-Lite SINGLE NONSEQ transfers
module ahb_cmd_master
  import ahb_pkg::*;
#(
  parameter int          AWIDTH    = 10,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [AWIDTH-1:0] CMD_ADDR,
  input  logic [1:0]        CMD_SIZE,
  input  logic [31:0]       CMD_WDATA,
  output logic              RSP_VALID,
  output logic [31:0]       RSP_RDATA,
  output logic              RSP_ERR,
  output logic              RSP_LOCAL,
  output logic [AWIDTH-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [3:0]        HPROT,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic              BUSY,
  output logic [15:0]       XFER_COUNT,
  output logic [7:0]        ERR_COUNT
);
  logic        dp_valid_q, dp_valid_d, dp_write_q, dp_write_d;
  logic [2:0]  dp_size_q, dp_size_d;
  logic [1:0]  dp_addr_q, dp_addr_d;
  logic [31:0] hwdata_q, hwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, rsp_local_q, rsp_local_d;
  logic [15:0] xfer_q, xfer_d;
  logic [7:0]  errc_q, errc_d;
  logic [2:0]  hsize;
  logic [31:0] wr_lanes, rd_lane;
  logic        aligned, cancel, bus_acc, loc_acc, done, bus_err;

  ahb_lane_mux u_lane (
    .wr_size (hsize),
    .wr_data (CMD_WDATA),
    .wr_lanes(wr_lanes),
    .rd_size (dp_size_q),
    .rd_addr (dp_addr_q),
    .rd_data (HRDATA),
    .rd_lane (rd_lane)
  );

  // address phase comes straight from the command; a pending local-error response blocks it
  always_comb begin
    hsize     = {1'b0, CMD_SIZE};
    aligned   = is_aligned(hsize, CMD_ADDR[1:0]);
    cancel    = dp_valid_q & HRESP & ~HREADY;
    CMD_READY = ~HRESET & HREADY & ~cancel & ~rsp_local_q & (aligned | ~dp_valid_q);
    bus_acc   = CMD_VALID & CMD_READY & aligned;
    loc_acc   = CMD_VALID & CMD_READY & ~aligned;
    done      = dp_valid_q & HREADY;
    bus_err   = HRESP == HRESP_ERROR;
    HTRANS    = (~HRESET & CMD_VALID & aligned & ~cancel & ~rsp_local_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
    HADDR     = HRESET ? '0 : CMD_ADDR;
    HWRITE    = ~HRESET & CMD_WRITE;
    HSIZE     = hsize;
    HBURST    = HBURST_SINGLE;
    HMASTLOCK = 1'b0;
    HPROT     = HPROT_VAL;
    HWDATA    = hwdata_q;
    BUSY      = dp_valid_q;
    RSP_VALID = rsp_valid_q;
    RSP_RDATA = rsp_rdata_q;
    RSP_ERR   = rsp_err_q;
    RSP_LOCAL = rsp_local_q;
    XFER_COUNT = xfer_q;
    ERR_COUNT  = errc_q;
  end

  // next-state for the data-phase register, response pulse and counters
  always_comb begin
    dp_valid_d  = bus_acc | (dp_valid_q & ~HREADY);
    dp_write_d  = bus_acc ? CMD_WRITE : dp_write_q;
    dp_size_d   = bus_acc ? hsize : dp_size_q;
    dp_addr_d   = bus_acc ? CMD_ADDR[1:0] : dp_addr_q;
    hwdata_d    = bus_acc ? wr_lanes : hwdata_q;
    rsp_valid_d = done | loc_acc;
    rsp_err_d   = done ? bus_err : loc_acc;
    rsp_local_d = loc_acc;
    rsp_rdata_d = (done & ~dp_write_q) ? rd_lane : '0;
    xfer_d      = xfer_q + 16'(done);
    errc_d      = (((done & bus_err) | loc_acc) & (errc_q != 8'hFF)) ? errc_q + 8'd1 : errc_q;
  end

  // state registers, cleared immediately by reset
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_size_q   <= '0;
      dp_addr_q   <= '0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_local_q <= 1'b0;
      rsp_rdata_q <= '0;
      xfer_q      <= '0;
      errc_q      <= '0;
    end else begin
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_size_q   <= dp_size_d;
      dp_addr_q   <= dp_addr_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_local_q <= rsp_local_d;
      rsp_rdata_q <= rsp_rdata_d;
      xfer_q      <= xfer_d;
      errc_q      <= errc_d;
    end
endmodule

// File: tb/tb_ahb_cmd_master.sv
// tb_ahb_cmd_master: directed and random commands against a memory slave and a byte-level reference model
module tb_ahb_cmd_master;
  import ahb_pkg::*;

  typedef struct {logic wr; logic [9:0] addr; logic [1:0] size; logic [31:0] wdata; int waits;} cmd_t;
  typedef struct {logic err; logic loc; logic [31:0] rdata;} rsp_t;

  localparam int ERR_BASE = 'h3C0;

  logic        clk = 1'b0, HRESET = 1'b1;
  logic        CMD_VALID = 1'b0, CMD_READY, CMD_WRITE = 1'b0;
  logic [9:0]  CMD_ADDR = '0;
  logic [1:0]  CMD_SIZE = '0;
  logic [31:0] CMD_WDATA = '0;
  logic        RSP_VALID, RSP_ERR, RSP_LOCAL;
  logic [31:0] RSP_RDATA;
  logic [9:0]  HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA, HRDATA = '0;
  logic        HREADY = 1'b1, HRESP = 1'b0;
  logic        BUSY;
  logic [15:0] XFER_COUNT;
  logic [7:0]  ERR_COUNT;

  ahb_cmd_master #(.AWIDTH(10), .HPROT_VAL(4'b0011)) dut (
    .HCLK(clk), .HRESET(HRESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_WRITE(CMD_WRITE), .CMD_ADDR(CMD_ADDR), .CMD_SIZE(CMD_SIZE), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .RSP_LOCAL(RSP_LOCAL),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP), .BUSY(BUSY), .XFER_COUNT(XFER_COUNT), .ERR_COUNT(ERR_COUNT)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  cmd_t cq[$];
  rsp_t eq[$];
  logic [1:0] htr_hist[$];
  logic [7:0] ref_mem [1024];
  logic [7:0] mem [1024];
  int m_xfer = 0, m_err = 0;
  logic s_act = 0, s_write = 0, s_err = 0, s_eph = 0, rsp_due = 0;
  logic [9:0] s_addr = '0;
  logic [1:0] s_size = '0;
  int s_waits = 0, kind = 0, prev_kind = 0;
  logic [31:0] prev_hwdata = '0, last_rdata = '0, last_hwdata = '0;
  logic [9:0]  prev_haddr = '0;
  logic [1:0]  prev_htrans = '0;
  logic [2:0]  last_hsize = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic bit misal(cmd_t c);
    return c.size == 2'd3 || (int'(c.addr) % (1 << c.size)) != 0;
  endfunction

  // reference: byte-addressed memory, little-endian, errors above ERR_BASE
  task automatic model(input cmd_t c, output rsp_t r);
    int n;
    n = 1 << c.size;
    r.err = 0; r.loc = 0; r.rdata = '0;
    if (misal(c)) begin
      r.err = 1; r.loc = 1;
    end else begin
      m_xfer++;
      if (int'(c.addr) >= ERR_BASE) r.err = 1;
      else for (int i = 0; i < n; i++)
        if (c.wr) ref_mem[int'(c.addr) + i] = c.wdata[8*i +: 8];
        else r.rdata[8*i +: 8] = ref_mem[int'(c.addr) + i];
    end
    if (r.err && m_err < 255) m_err++;
  endtask

  task automatic push(input logic wr, input logic [9:0] addr, input logic [1:0] size, input logic [31:0] wdata, input int waits);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.size = size; c.wdata = wdata; c.waits = waits;
    cq.push_back(c);
  endtask

  task automatic cycle();
    rsp_t r;
    cmd_t c;
    int wa;
    @(negedge clk);
    chk("rsp_timing", 32'(RSP_VALID), 32'(rsp_due));
    if (RSP_VALID && eq.size() > 0) begin
      r = eq.pop_front();
      chk("rsp_err", 32'(RSP_ERR), 32'(r.err));
      chk("rsp_local", 32'(RSP_LOCAL), 32'(r.loc));
      chk("rsp_rdata", RSP_RDATA, r.rdata);
      last_rdata = RSP_RDATA;
    end
    rsp_due = 0;
    kind = 0; HREADY = 1; HRESP = 0; HRDATA = $urandom();
    if (s_act) begin
      wa = int'({s_addr[9:2], 2'b00});
      if (s_waits > 0) begin kind = 1; HREADY = 0; end
      else if (s_err && !s_eph) begin kind = 2; HREADY = 0; HRESP = 1; end
      else begin
        kind = 3; HRESP = s_err;
        HRDATA = s_err ? 32'h0 : {mem[wa+3], mem[wa+2], mem[wa+1], mem[wa]};
      end
    end
    CMD_VALID = cq.size() > 0;
    if (CMD_VALID) begin
      CMD_WRITE = cq[0].wr; CMD_ADDR = cq[0].addr; CMD_SIZE = cq[0].size; CMD_WDATA = cq[0].wdata;
    end
    #1;
    htr_hist.push_back(HTRANS);
    if (CMD_VALID && misal(cq[0])) chk("htrans_misal", 32'(HTRANS), 32'(HTRANS_IDLE));
    if (kind == 1 && prev_kind == 1) begin
      chk("hold_hwdata", HWDATA, prev_hwdata);
      chk("hold_haddr", 32'(HADDR), 32'(prev_haddr));
      chk("hold_htrans", 32'(HTRANS), 32'(prev_htrans));
    end
    if (kind == 2) begin
      chk("htrans_err1", 32'(HTRANS), 32'(HTRANS_IDLE));
      chk("ready_err1", 32'(CMD_READY), 32'(0));
    end
    if (kind == 3 && CMD_VALID && !misal(cq[0])) chk("accept_on_done", 32'(CMD_READY), 32'(1));
    if (kind == 1) s_waits--;
    if (kind == 2) s_eph = 1;
    if (kind == 3) begin
      if (s_write && !s_err)
        for (int i = 0; i < (1 << s_size); i++) mem[int'(s_addr) + i] = HWDATA[8*((int'(s_addr) + i) % 4) +: 8];
      last_hwdata = HWDATA;
      s_act = 0;
      rsp_due = 1;
    end
    if (HREADY && HTRANS == HTRANS_NONSEQ) begin
      chk("nonseq_has_cmd", 32'(cq.size() > 0), 32'(1));
      if (cq.size() > 0) begin
        chk("haddr", 32'(HADDR), 32'(cq[0].addr));
        s_act = 1; s_addr = HADDR; s_write = HWRITE; s_size = HSIZE[1:0];
        s_waits = cq[0].waits; s_err = int'(HADDR) >= ERR_BASE; s_eph = 0;
        last_hsize = HSIZE;
      end
    end
    if (CMD_VALID && CMD_READY) begin
      c = cq.pop_front();
      model(c, r);
      eq.push_back(r);
      if (misal(c)) rsp_due = 1;
    end
    prev_kind = kind; prev_hwdata = HWDATA; prev_haddr = HADDR; prev_htrans = HTRANS;
  endtask

  task automatic drain();
    for (int i = 0; i < 5000 && (cq.size() > 0 || eq.size() > 0 || s_act); i++) cycle();
    chk("drain_left", 32'(cq.size() + eq.size()), 32'(0));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    #1;
    chk("rst_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
    chk("rst_busy", 32'(BUSY), 32'(0));
    chk("rst_rsp_valid", 32'(RSP_VALID), 32'(0));
    chk("rst_xfer", 32'(XFER_COUNT), 32'(0));
    chk("rst_err", 32'(ERR_COUNT), 32'(0));
    @(negedge clk);
    HRESET = 0;
    // word write then word read, back to back
    htr_hist.delete();
    push(1, 10'h00C, 2'd2, 32'hDEADBEEF, 0);
    push(0, 10'h00C, 2'd2, 32'h0, 0);
    drain();
    chk("b2b_nonseq0", 32'(htr_hist[0]), 32'(HTRANS_NONSEQ));
    chk("b2b_nonseq1", 32'(htr_hist[1]), 32'(HTRANS_NONSEQ));
    chk("rd_word", last_rdata, 32'hDEADBEEF);
    chk("xfer_2", 32'(XFER_COUNT), 32'(2));
    // byte write lane replication, then byte read extraction
    push(1, 10'h00D, 2'd0, 32'h000000A5, 0);
    drain();
    chk("byte_hwdata", last_hwdata, 32'hA5A5A5A5);
    chk("byte_hsize", 32'(last_hsize), 32'(0));
    push(0, 10'h00D, 2'd0, 32'h0, 0);
    drain();
    chk("rd_byte", last_rdata, 32'h000000A5);
    // three wait states on a read with a write queued behind it
    push(0, 10'h00C, 2'd2, 32'h0, 3);
    push(1, 10'h020, 2'd1, 32'h00001234, 0);
    drain();
    // two-cycle error on a write with a read queued
    push(1, 10'h3C4, 2'd2, 32'h11223344, 0);
    push(0, 10'h020, 2'd1, 32'h0, 0);
    drain();
    chk("err_count_1", 32'(ERR_COUNT), 32'(1));
    chk("rd_after_err", last_rdata, 32'h00001234);
    // misaligned half read
    push(0, 10'h003, 2'd1, 32'h0, 0);
    drain();
    chk("xfer_after_misal", 32'(XFER_COUNT), 32'(8));
    chk("err_after_misal", 32'(ERR_COUNT), 32'(2));
    // random traffic
    for (int k = 0; k < 400; k++)
      push(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3)), $urandom(), int'($urandom_range(0, 3)));
    drain();
    chk("xfer_model", 32'(XFER_COUNT), 32'(m_xfer % 65536));
    chk("err_model", 32'(ERR_COUNT), 32'(m_err));
    // reset during a read wait state
    push(0, 10'h010, 2'd2, 32'h0, 6);
    push(1, 10'h014, 2'd2, 32'h55AA55AA, 0);
    for (int k = 0; k < 3; k++) cycle();
    chk("pre_rst_busy", 32'(BUSY), 32'(1));
    HRESET = 1;
    #1;
    chk("mid_rst_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
    chk("mid_rst_busy", 32'(BUSY), 32'(0));
    chk("mid_rst_xfer", 32'(XFER_COUNT), 32'(0));
    chk("mid_rst_err", 32'(ERR_COUNT), 32'(0));
    cq.delete(); eq.delete();
    s_act = 0; rsp_due = 0; prev_kind = 0; m_xfer = 0; m_err = 0;
    CMD_VALID = 0; HREADY = 1; HRESP = 0;
    @(negedge clk);
    HRESET = 0;
    for (int k = 0; k < 6; k++) cycle();
    chk("post_rst_xfer", 32'(XFER_COUNT), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
